// File: rtl/full_hash_pkg.sv
// Shared definitions for the hash output path.
// Holds the digest geometry, the ASCII code points used by the hex
// formatter, and the serializer state encoding.
package full_hash_pkg;

  localparam int DIGEST_W = 64;
  localparam int NIBBLES  = DIGEST_W / 4;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_NL = 8'h0A;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational hex digit formatter: one 4-bit nibble to one ASCII byte.
// Ports:
//   nibble - value 0..15
//   ascii  - '0'..'9' for 0..9, then 'a'..'f' (or 'A'..'F' when UPPERCASE)
module nibble_to_ascii
  import full_hash_pkg::*;
#(
  parameter bit UPPERCASE = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_0 + {4'd0, nibble};
    if (nibble > 4'd9) begin
      ascii = (UPPERCASE ? ASCII_UA : ASCII_LA) + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/digest_hex_serializer.sv
// Captures a 64-bit digest on the rising edge of hash_ready and streams it
// as ASCII hex, most-significant nibble first, over a byte valid/ready
// interface, optionally terminated by a newline.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   hash_ready      - level from hash core; a 0->1 transition requests capture
//   digest_out      - digest, sampled on the capture cycle
//   ch_ready        - downstream accepts ch_data this cycle
//   ch_valid        - ch_data holds a character
//   ch_data         - ASCII character (0 when idle)
//   ch_last         - marks the final character of a digest
//   busy            - a captured digest is still being sent
//   overrun         - one-cycle pulse: a capture request arrived while busy
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing to send; waiting for a rise on hash_ready
// SEND  | presenting character cnt of the captured digest until accepted
module digest_hex_serializer
  import full_hash_pkg::*;
#(
  parameter bit APPEND_NEWLINE = 1'b1,
  parameter bit UPPERCASE      = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hash_ready,
  input  logic [DIGEST_W-1:0] digest_out,
  input  logic                ch_ready,
  output logic                ch_valid,
  output logic [7:0]          ch_data,
  output logic                ch_last,
  output logic                busy,
  output logic                overrun
);

  // Index of the final character: the newline slot sits just past the nibbles.
  localparam logic [4:0] LAST_CNT = APPEND_NEWLINE ? 5'(NIBBLES) : 5'(NIBBLES - 1);
  localparam logic [4:0] NL_CNT   = 5'(NIBBLES);

  ser_state_e          state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic                hr_q;
  logic                overrun_q, overrun_d;
  logic                rise;
  logic [3:0]          nib_idx;
  logic [3:0]          nib_sel;
  logic [7:0]          nib_ascii;

  assign rise = hash_ready & ~hr_q;

  // Character cnt shows nibble 15-cnt. On the newline slot cnt[3:0] wraps to
  // 0 and the selected nibble is simply not used.
  assign nib_idx = 4'(NIBBLES - 1) - cnt_q[3:0];
  assign nib_sel = digest_q[{nib_idx, 2'b00} +: 4];

  nibble_to_ascii #(
    .UPPERCASE(UPPERCASE)
  ) u_nibble_to_ascii (
    .nibble(nib_sel),
    .ascii (nib_ascii)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      digest_q  <= '0;
      hr_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digest_q  <= digest_d;
      hr_q      <= hash_ready;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    digest_d  = digest_q;
    overrun_d = 1'b0;
    ch_valid  = 1'b0;
    ch_data   = 8'h00;
    ch_last   = 1'b0;
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          digest_d = digest_out;
          cnt_d    = 5'd0;
          state_d  = SEND;
        end
      end
      SEND: begin
        ch_valid  = 1'b1;
        busy      = 1'b1;
        ch_last   = (cnt_q == LAST_CNT);
        ch_data   = (APPEND_NEWLINE && (cnt_q == NL_CNT)) ? ASCII_NL : nib_ascii;
        // Includes a rise coinciding with the final transfer.
        overrun_d = rise;
        if (ch_ready) begin
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun = overrun_q;

endmodule

// File: doc/digest_hex_serializer.md
Name: digest_hex_serializer

Overview:
Downstream stage of full_hash_aes_top. Captures the 64-bit digest when hash_ready rises. Streams the digest as lowercase ASCII hex characters, most-significant nibble first, over a byte valid/ready interface to the UART/log path, optionally followed by a newline. It replaces the bench-side hextoa formatting with synthesizable logic.

Parameters:
APPEND_NEWLINE, 1, when 1 a 0x0A byte follows the 16 hex chars (17 chars total), when 0 exactly 16 chars
UPPERCASE, 0, when 1 hex letters are 'A'-'F' (0x41-0x46), else 'a'-'f' (0x61-0x66)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
hash_ready  in  1  level from hash core, digest_out valid while high
digest_out  in  64  digest from hash core, byte 7 (bits 63:56) printed first
ch_ready  in  1  downstream accepts a character this cycle
ch_valid  out  1  ch_data holds a valid character
ch_data  out  8  ASCII character
ch_last  out  1  high with the final character of a digest
busy  out  1  a digest is captured and not yet fully sent
overrun  out  1  single-cycle pulse: rising hash_ready was dropped because busy

Behaviour:
- Reset: on a clk edge with rst_n=0, the following are cleared: ch_valid=0, ch_data=0, ch_last=0, busy=0, overrun=0, state=IDLE, char counter=0, hr_q=0, digest register=0. Reset mid-stream aborts the stream. No partial character is held.
- Rise detection: hr_q registers hash_ready. A rise is hash_ready=1 && hr_q=0. Because hr_q resets to 0, hash_ready held high through reset release counts as one rise on the first cycle after reset. Holding hash_ready high never causes a recapture.
- IDLE: on a rise, digest_out is captured, cnt=0, state becomes SEND, busy=1. ch_valid=1 with the first char from the next cycle (1-cycle latency from sampled rise to ch_valid).
- SEND: ch_data = ascii(nibble[15-cnt]) while cnt<16. If cnt=16 (APPEND_NEWLINE=1 only), ch_data=0x0A.
- Transfer occurs on an edge with ch_valid && ch_ready. The next char appears the following cycle with no bubble. Full throughput is one char per cycle when ch_ready is held high.
- Backpressure: while ch_valid && !ch_ready, ch_data and ch_last hold stable. ch_valid never drops before the transfer.
- ch_last=1 only with the final char: cnt=15 when APPEND_NEWLINE=0, cnt=16 when APPEND_NEWLINE=1.
- On transfer of the last char: state becomes IDLE, ch_valid=0, busy=0 next cycle. Earliest next capture is a rise sampled in that IDLE cycle.
- A rise that is sampled while state=SEND is ignored. overrun pulses for exactly that cycle. The captured digest is unaffected.
- A rise on the same edge as the last-char transfer still counts as overrun (state is SEND at that edge).
- Mapping: nibble 0-9 maps to 0x30+n. Nibble 10-15 maps to 0x61+(n-10), or 0x41+(n-10) if UPPERCASE.
- Counter width is 5 bits. No wrap is possible: the counter is bounded by the char count.

Decomposition:
- Shared package full_hash_pkg holds: DIGEST_W=64, NIBBLES=DIGEST_W/4, ASCII_0=8'h30, ASCII_LA=8'h61, ASCII_UA=8'h41, ASCII_NL=8'h0A, and the state enum {IDLE, SEND}.
- One combinational sub-module, nibble_to_ascii (in 4, in UPPERCASE param, out 8), instantiated once on the selected nibble.

Test Plan:
- Basic: ch_ready=1, digest_out=64'h0123456789ABCDEF, hash_ready rises and stays high. Expected: 17 consecutive chars 0x30,0x31,...,0x39,0x61..0x66,0x0A; ch_last only on 0x0A; busy low after; no second stream while hash_ready stays high.
- Backpressure: digest 64'hFFFF0000DEADBEEF with ch_ready randomly toggled (~50%). Expected: received string "ffff0000deadbeef\n"; ch_data and ch_last stable on every stalled cycle.
- Params: UPPERCASE=1, APPEND_NEWLINE=0, digest 64'h00000000000000AB. Expected: exactly 16 chars "00000000000000AB"; ch_last on 'B' (0x42).
- Overrun: during a stream, drop hash_ready then raise it with digest 64'h1. Expected: overrun is a one-cycle pulse; the first stream completes with the original digest; no extra chars follow.
- Reset mid-stream: assert rst_n=0 for 1 cycle after 5 chars with hash_ready held high. Expected: ch_valid=0 and busy=0 during reset; after release the full 17-char stream restarts from char 0 (the rise is re-detected).
- Back-to-back: a rise sampled in the first IDLE cycle after the last char. Expected: the new stream starts the next cycle; overrun=0.
